// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the incoming instruction into a
// registered, elastic output bundle backed by a one-entry skid buffer.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            reg_write,
  output logic [1:0]      op_a_sel,
  output logic            op_b_sel,
  output logic [1:0]      wb_sel,
  output logic            pc_sel_bit0,
  output logic            branch,
  output logic            jop,
  output logic            mem_access,
  output logic [4:0]      alu_ctl,
  output logic            illegal
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("decode_stage supports XLEN=32 only");
  end

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic [1:0]      op_a_sel;
    logic            op_b_sel;
    logic [1:0]      wb_sel;
    logic            pc_sel_bit0;
    logic            branch;
    logic            jop;
    logic            mem_access;
    logic [4:0]      alu_ctl;
    logic            illegal;
  } bundle_t;

  // instr[30] selects SUB only for register-register ops; SRA for both shift forms.
  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_op);
    case (f3)
      3'b000:  alu_of = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  function automatic bundle_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bundle_t b;
    logic signed [XLEN-1:0] imm_s;
    logic has_rd, has_rs1, has_rs2, has_f3, bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    b = '0;
    imm_s = '0;
    has_rd = 1'b0; has_rs1 = 1'b0; has_rs2 = 1'b0; has_f3 = 1'b0; bad = 1'b0;
    b.pc = pc;
    b.opcode = ins[6:0];
    b.alu_ctl = ALU_ADD;
    case (ins[6:0])
      OPC_LUI: begin
        has_rd = 1'b1; b.op_a_sel = 2'b10;
        imm_s = $signed({ins[31:12], 12'b0});
      end
      OPC_AUIPC: begin
        has_rd = 1'b1; b.op_a_sel = 2'b01;
        imm_s = $signed({ins[31:12], 12'b0});
      end
      OPC_JAL: begin
        has_rd = 1'b1; b.op_a_sel = 2'b01; b.wb_sel = 2'b10; b.pc_sel_bit0 = 1'b1;
        imm_s = $signed({{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
      end
      OPC_JALR: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_f3 = 1'b1;
        b.wb_sel = 2'b10; b.pc_sel_bit0 = 1'b1; b.jop = 1'b1;
        imm_s = $signed({{20{ins[31]}}, ins[31:20]});
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1; b.branch = 1'b1;
        imm_s = $signed({{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0});
        bad = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_f3 = 1'b1;
        b.wb_sel = 2'b01; b.mem_access = 1'b1;
        imm_s = $signed({{20{ins[31]}}, ins[31:20]});
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1; b.mem_access = 1'b1;
        imm_s = $signed({{20{ins[31]}}, ins[31:25], ins[11:7]});
        bad = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_f3 = 1'b1;
        imm_s = $signed({{20{ins[31]}}, ins[31:20]});
        b.alu_ctl = alu_of(f3, ins[30], 1'b0);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm_s = $signed({27'b0, ins[24:20]});
          b.funct7 = f7;
          bad = !((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'b101));
        end
      end
      OPC_OP: begin
        has_rd = 1'b1; has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1;
        b.funct7 = f7; b.op_b_sel = 1'b1;
        if (f7 == 7'h01) begin
          bad = !EN_M;
          b.alu_ctl = {2'b10, f3};
        end else begin
          b.alu_ctl = alu_of(f3, ins[30], 1'b1);
          bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      default: bad = 1'b1;
    endcase
    b.rd        = has_rd  ? ins[11:7]  : 5'd0;
    b.rs1       = has_rs1 ? ins[19:15] : 5'd0;
    b.rs2       = has_rs2 ? ins[24:20] : 5'd0;
    b.funct3    = has_f3  ? f3         : 3'd0;
    b.imm       = imm_s;
    b.reg_write = has_rd && (ins[11:7] != 5'd0) && !bad;
    // Illegal bundles still flow downstream but must have no architectural side effects.
    if (bad) begin
      b.mem_access  = 1'b0;
      b.branch      = 1'b0;
      b.jop         = 1'b0;
      b.pc_sel_bit0 = 1'b0;
      b.alu_ctl     = ALU_ADD;
    end
    b.illegal = bad;
    return b;
  endfunction

  // stage p0: combinational decode of the incoming instruction
  bundle_t dec_p0;
  logic    accept, out_free;

  always_comb begin
    dec_p0 = decode(in_instr, in_pc);
  end

  // stage p1: output register plus skid entry
  bundle_t bnd_p1, skd_p1;
  logic    vld_p1, skd_vld_p1;

  assign out_free = ~vld_p1 | out_ready;
  assign in_ready = rst_n & (SKID ? ~skd_vld_p1 : out_free);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      skd_vld_p1 <= 1'b0;
      bnd_p1     <= '0;
      skd_p1     <= '0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      skd_vld_p1 <= 1'b0;
    end else if (out_free) begin
      if (skd_vld_p1) begin
        bnd_p1     <= skd_p1;
        vld_p1     <= 1'b1;
        skd_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) bnd_p1 <= dec_p0;
      end
    end else if (accept && SKID) begin
      skd_p1     <= dec_p0;
      skd_vld_p1 <= 1'b1;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = bnd_p1.pc;
  assign opcode      = bnd_p1.opcode;
  assign rd          = bnd_p1.rd;
  assign rs1         = bnd_p1.rs1;
  assign rs2         = bnd_p1.rs2;
  assign funct3      = bnd_p1.funct3;
  assign funct7      = bnd_p1.funct7;
  assign imm         = bnd_p1.imm;
  assign reg_write   = bnd_p1.reg_write;
  assign op_a_sel    = bnd_p1.op_a_sel;
  assign op_b_sel    = bnd_p1.op_b_sel;
  assign wb_sel      = bnd_p1.wb_sel;
  assign pc_sel_bit0 = bnd_p1.pc_sel_bit0;
  assign branch      = bnd_p1.branch;
  assign jop         = bnd_p1.jop;
  assign mem_access  = bnd_p1.mem_access;
  assign alu_ctl     = bnd_p1.alu_ctl;
  assign illegal     = bnd_p1.illegal;

endmodule
